// File: rtl/ps2_pkg.sv
// PS/2 receive path shared definitions.
//   ps2_state_t    - receive FSM states
//   PS2_DATA_BITS  - payload bits per frame
//   PS2_FRAME_BITS - total bits per frame (start, data, parity, stop)
//   odd_parity_ok  - true when the data byte plus parity bit hold an odd number of ones
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    WRITE  = 3'd4
  } ps2_state_t;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data_byte,
                                         input logic                     p);
    return ^{data_byte, p};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Input conditioning for the PS/2 pins.
//   clock, reset  - system clock, synchronous active-high reset
//   ps2_clk       - raw PS/2 clock pin (asynchronous)
//   ps2_data      - raw PS/2 data pin (asynchronous)
//   fall          - 1-cycle pulse on a falling edge of the filtered PS/2 clock
//   data_s        - synchronized PS/2 data, aligned with fall
// Both pins go through 2-flop synchronizers. The clock level only changes after
// FILTER_LEN consecutive synchronized samples disagree with the current level,
// so short glitches on the cable never produce a fall pulse.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_s
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FILTER_LEN - 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_filt;
  logic [CW-1:0] stab_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_filt <= 1'b1;
      stab_cnt <= CNT_LOAD;
      fall     <= 1'b0;
      data_s   <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      data_s   <= dat_sync[1];
      fall     <= 1'b0;
      // Down-counter reloads whenever the sample agrees with the filtered level;
      // terminal count on a disagreeing sample means FILTER_LEN in a row.
      if (clk_sync[1] == clk_filt) begin
        stab_cnt <= CNT_LOAD;
      end else if (stab_cnt == '0) begin
        clk_filt <= clk_sync[1];
        stab_cnt <= CNT_LOAD;
        fall     <= clk_filt;
      end else begin
        stab_cnt <= stab_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_rx_ram_writer.sv
// PS/2 frame receiver feeding the RAMps2 scancode ring buffer write port.
//   clock, reset  - system clock, synchronous active-high reset
//   ps2_clk/data  - raw PS/2 pins
//   wraddress     - RAM write address (holds last written address)
//   data          - RAM write data (holds last written byte)
//   wren          - 1-cycle write strobe per valid frame
//   frame_count   - bytes written since reset, wraps at 256
//   parity_err    - 1-cycle pulse, frame dropped for bad parity
//   frame_err     - 1-cycle pulse, frame dropped for stop bit 0 or timeout
//   busy          - high while a frame is in progress
//
// state  | meaning
// IDLE   | waiting for a start bit (fall with data low)
// DATA   | shifting in D0..D7, LSB first
// PARITY | waiting for the parity bit
// STOP   | waiting for the stop bit, then judge the frame
// WRITE  | wren high for this cycle, pointer advances at its end
module ps2_rx_ram_writer
  import ps2_pkg::*;
#(
  parameter int ADDR_W         = 4,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  output logic [ADDR_W-1:0] wraddress,
  output logic [7:0]        data,
  output logic              wren,
  output logic [7:0]        frame_count,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    BIT_LAST = 3'(PS2_DATA_BITS - 1);

  logic                     fall;
  logic                     data_s;
  ps2_state_t               state;
  logic [PS2_DATA_BITS-1:0] shreg;
  logic                     par_bit;
  logic [2:0]               bit_cnt;
  logic [TW-1:0]            to_cnt;
  logic [ADDR_W-1:0]        ptr;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_line_filter (
    .clock    (clock),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .fall     (fall),
    .data_s   (data_s)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      par_bit     <= 1'b0;
      bit_cnt     <= '0;
      to_cnt      <= '0;
      ptr         <= '0;
      wraddress   <= '0;
      data        <= '0;
      wren        <= 1'b0;
      frame_count <= '0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      wren       <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          to_cnt <= '0;
          // A fall with data high is line noise, not a start bit.
          if (fall && !data_s) begin
            state   <= DATA;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end

        DATA, PARITY, STOP: begin
          if (fall) begin
            to_cnt <= '0;
            if (state == DATA) begin
              shreg   <= {data_s, shreg[PS2_DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) state <= PARITY;
            end else if (state == PARITY) begin
              par_bit <= data_s;
              state   <= STOP;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              if (!odd_parity_ok(shreg, par_bit)) begin
                parity_err <= 1'b1;
              end else if (!data_s) begin
                frame_err <= 1'b1;
              end else begin
                state     <= WRITE;
                busy      <= 1'b1;
                wren      <= 1'b1;
                data      <= shreg;
                wraddress <= ptr;
              end
            end
          end else if (to_cnt == TO_LAST) begin
            // Device stalled mid-frame: drop the partial byte.
            frame_err <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
            to_cnt    <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        WRITE: begin
          // No full flag: the ring silently overwrites the oldest entry.
          ptr         <= ptr + 1'b1;
          frame_count <= frame_count + 8'd1;
          state       <= IDLE;
          busy        <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_rx_ram_writer.sv
// Self-checking bench for ps2_rx_ram_writer. PS/2 timing and the timeout are
// scaled down so the run stays short; a behavioural ring model predicts every
// write, pointer and counter value.
module tb_ps2_rx_ram_writer;
  import ps2_pkg::*;

  localparam int ADDR_W  = 4;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int FL      = 8;
  localparam int TO      = 600;
  localparam int HALF    = 40;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              ps2_clk = 1'b1;
  logic              ps2_data = 1'b1;
  logic [ADDR_W-1:0] wraddress;
  logic [7:0]        data;
  logic              wren;
  logic [7:0]        frame_count;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  ps2_rx_ram_writer #(
    .ADDR_W         (ADDR_W),
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .wraddress   (wraddress),
    .data        (data),
    .wren        (wren),
    .frame_count (frame_count),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  // Downstream RAM (stands in for RAMps2) plus event totals.
  logic [7:0] ram_tb [DEPTH];
  int wren_tot = 0, perr_tot = 0, ferr_tot = 0, excl_err = 0;

  always @(negedge clock) begin
    if (wren) begin
      wren_tot++;
      ram_tb[wraddress] = data;
    end
    if (parity_err) perr_tot++;
    if (frame_err)  ferr_tot++;
    if (int'(wren) + int'(parity_err) + int'(frame_err) > 1) excl_err++;
  end

  // Reference model: ring contents, write pointer, byte count.
  logic [7:0] ram_m [DEPTH];
  int ptr_m = 0;
  int cnt_m = 0;

  // kind bit0: parity wrong, bit1: stop bit 0.
  function automatic logic [PS2_FRAME_BITS-1:0] make_frame(input logic [7:0] b, input int kind);
    logic par;
    logic stp;
    par = ~(^b);
    if (kind & 1) par = ~par;
    stp = (kind & 2) ? 1'b0 : 1'b1;
    return {stp, par, b, 1'b0};
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bits(input logic [PS2_FRAME_BITS-1:0] bits, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      if (glitch && i == 5) begin
        // Low blip shorter than the filter length while the clock is high.
        wait_cycles(10);
        ps2_clk = 1'b0;
        wait_cycles(3);
        ps2_clk = 1'b1;
        wait_cycles(HALF - 13);
      end else begin
        wait_cycles(HALF);
      end
      ps2_clk = 1'b0;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic do_frame(input logic [7:0] b, input int kind, input bit glitch, input string tag);
    int w0, p0, f0, addr;
    w0 = wren_tot; p0 = perr_tot; f0 = ferr_tot;
    send_bits(make_frame(b, kind), PS2_FRAME_BITS, glitch);
    ps2_data = 1'b1;
    wait_cycles(HALF + 30);
    if (kind == 0) begin
      addr = ptr_m;
      ram_m[addr] = b;
      ptr_m = (ptr_m + 1) % DEPTH;
      cnt_m = (cnt_m + 1) % 256;
      check({tag, "_data"}, int'(data), int'(b));
      check({tag, "_addr"}, int'(wraddress), addr);
      check({tag, "_ram"},  int'(ram_tb[addr]), int'(ram_m[addr]));
    end
    check({tag, "_wren"}, wren_tot - w0, (kind == 0) ? 1 : 0);
    check({tag, "_perr"}, perr_tot - p0, (kind & 1) ? 1 : 0);
    check({tag, "_ferr"}, ferr_tot - f0, (kind == 2) ? 1 : 0);
    check({tag, "_count"}, int'(frame_count), cnt_m);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    ptr_m = 0;
    cnt_m = 0;
    wait_cycles(2);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wraddr"}, int'(wraddress), 0);
    check({tag, "_data"},   int'(data), 0);
    check({tag, "_wren"},   int'(wren), 0);
    check({tag, "_count"},  int'(frame_count), 0);
    check({tag, "_perr"},   int'(parity_err), 0);
    check({tag, "_ferr"},   int'(frame_err), 0);
    check({tag, "_busy"},   int'(busy), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, p0, f0, waited;
    logic [7:0] rb;
    int kind;

    for (int i = 0; i < DEPTH; i++) begin
      ram_tb[i] = 8'h00;
      ram_m[i]  = 8'h00;
    end

    do_reset();
    check_idle_outputs("reset");

    do_frame(8'h1C, 0, 1'b0, "f1c");
    do_frame(8'hF0, 0, 1'b0, "ff0");
    do_frame(8'h1C, 0, 1'b0, "f1c_b");
    do_frame(8'h1C, 1, 1'b0, "par_bad");
    do_frame(8'h1C, 2, 1'b0, "stop_bad");
    do_frame(8'h1C, 3, 1'b0, "both_bad");

    // Stall after start + 5 data bits.
    w0 = wren_tot; f0 = ferr_tot;
    send_bits(make_frame(8'h3C, 0), 6, 1'b0);
    check("to_busy_mid", int'(busy), 1);
    waited = 0;
    while (ferr_tot == f0 && waited < 3 * TO) begin
      @(negedge clock);
      waited++;
    end
    check("to_ferr", ferr_tot - f0, 1);
    check("to_window", int'(waited >= TO - HALF + 5 && waited <= TO - HALF + 15), 1);
    check("to_busy", int'(busy), 0);
    check("to_wren", wren_tot - w0, 0);
    check("to_count", int'(frame_count), cnt_m);
    do_frame(8'h5A, 0, 1'b0, "after_to");

    do_frame(8'hA7, 0, 1'b1, "glitch");

    for (int i = 0; i < 24; i++) begin
      rb   = 8'($urandom);
      kind = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 0) kind = 0;
      do_frame(rb, kind, 1'b0, "rand");
    end

    // Ring wrap: 17 writes from reset land the last one back at address 0.
    do_reset();
    for (int i = 0; i <= 16; i++) do_frame(8'(i), 0, 1'b0, "wrap");
    check("wrap_ram0", int'(ram_tb[0]), 8'h10);
    check("wrap_addr", int'(wraddress), 0);
    check("wrap_count", int'(frame_count), 17);
    check("wrap_ptr", ptr_m, 1);
    do_frame(8'h99, 0, 1'b0, "wrap_next");

    // Reset after the 4th data bit: nothing may come out of the dropped frame.
    w0 = wren_tot; p0 = perr_tot; f0 = ferr_tot;
    send_bits(make_frame(8'hA5, 0), 5, 1'b0);
    do_reset();
    check_idle_outputs("midreset");
    wait_cycles(2 * TO);
    check("midreset_wren", wren_tot - w0, 0);
    check("midreset_perr", perr_tot - p0, 0);
    check("midreset_ferr", ferr_tot - f0, 0);
    do_frame(8'h77, 0, 1'b0, "post_reset");

    check("exclusive_pulses", excl_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
